ram_port_arbiter: RTL and testbench

Single-port arbiter that shares the 32K x 16 data RAM between the core data port and the display scan-out reader. It sits between the address-decode/dispatch logic and the RAM. It grants one access per cycle, registers the RAM command, and routes read data back to the requester that issued it. The display has priority, with a starvation bound that guarantees the core forward progress.

---
 rtl/ram_port_arbiter_if.sv | 43 ++++
 rtl/ram_port_arbiter.sv | 105 ++++++++++
 tb/tb_ram_port_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Requester, display and RAM command bundle for the data-RAM arbiter.
// The master side is the requesters plus the RAM; the slave side is the arbiter.
interface ram_port_arbiter_if #(
    parameter int AW = 15,
    parameter int DW = 16
);
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_gnt;
    logic          core_rvalid;
    logic [DW-1:0] core_rdata;

    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_gnt;
    logic          vid_rvalid;
    logic [DW-1:0] vid_rdata;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_rvalid, core_rdata,
        output vid_req, vid_addr,
        input  vid_gnt, vid_rvalid, vid_rdata,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_rvalid, core_rdata,
        input  vid_req, vid_addr,
        output vid_gnt, vid_rvalid, vid_rdata,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares the single-port data RAM between core and display scan-out.
// Display wins by default; a saturating starve counter lets the core through.
module ram_port_arbiter #(
    parameter int AW           = 15,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              rst,
    ram_port_arbiter_if.slave bus
);
    localparam logic [7:0] Limit = 8'(STARVE_LIMIT);

    logic [7:0]    starveCnt;
    logic          coreWin;
    logic          vidGnt;
    logic          coreGnt;
    logic [AW-1:0] ramAddr;
    logic          ramWe;
    logic [DW-1:0] ramWdata;
    logic          tagValid0;
    logic          tagCore0;
    logic          tagValid1;
    logic          tagCore1;
    logic [DW-1:0] coreHold;
    logic [DW-1:0] vidHold;
    logic          coreRvalid;
    logic          vidRvalid;

    // Grant: display first, core once it has been denied Limit times in a row.
    always_comb begin
        coreWin = bus.core_req && (starveCnt == Limit);
        vidGnt  = !rst && bus.vid_req && !coreWin;
        coreGnt = !rst && bus.core_req && !vidGnt;
    end

    // Starve counter: counts consecutive denied core cycles, saturating.
    always_ff @(posedge clk) begin
        if (rst || !bus.core_req || coreGnt)
            starveCnt <= '0;
        else if (starveCnt != Limit)
            starveCnt <= starveCnt + 8'd1;
    end

    // RAM command register; the display port can only read.
    always_ff @(posedge clk) begin
        if (rst) begin
            ramAddr  <= '0;
            ramWe    <= 1'b0;
            ramWdata <= '0;
        end else if (vidGnt) begin
            ramAddr  <= bus.vid_addr;
            ramWe    <= 1'b0;
        end else if (coreGnt) begin
            ramAddr  <= bus.core_addr;
            ramWe    <= bus.core_we;
            ramWdata <= bus.core_wdata;
        end else begin
            ramWe    <= 1'b0;
        end
    end

    // Two-stage owner tag, lined up with the RAM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            tagValid0 <= 1'b0;
            tagCore0  <= 1'b0;
            tagValid1 <= 1'b0;
            tagCore1  <= 1'b0;
        end else begin
            tagValid0 <= vidGnt || (coreGnt && !bus.core_we);
            tagCore0  <= coreGnt;
            tagValid1 <= tagValid0;
            tagCore1  <= tagCore0;
        end
    end

    always_comb begin
        coreRvalid = tagValid1 && tagCore1;
        vidRvalid  = tagValid1 && !tagCore1;
    end

    // Last returned word per requester, shown while that requester is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            coreHold <= '0;
            vidHold  <= '0;
        end else begin
            if (coreRvalid)
                coreHold <= bus.ram_rdata;
            if (vidRvalid)
                vidHold <= bus.ram_rdata;
        end
    end

    assign bus.core_gnt    = coreGnt;
    assign bus.vid_gnt     = vidGnt;
    assign bus.core_rvalid = coreRvalid;
    assign bus.vid_rvalid  = vidRvalid;
    assign bus.core_rdata  = coreRvalid ? bus.ram_rdata : coreHold;
    assign bus.vid_rdata   = vidRvalid ? bus.ram_rdata : vidHold;
    assign bus.ram_addr    = ramAddr;
    assign bus.ram_we      = ramWe;
    assign bus.ram_wdata   = ramWdata;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 32K x 16 RAM.
// RAM is preloaded with addr ^ 16'hA5A5 so display reads have known data.
module tb_ram_port_arbiter;
    localparam logic [15:0] PA = 16'h0020 ^ 16'hA5A5;

    typedef struct {
        logic        rst;
        logic        cReq;
        logic        cWe;
        logic [14:0] cAddr;
        logic [15:0] cWd;
        logic        vReq;
        logic [14:0] vAddr;
        logic        eCG;
        logic        eVG;
        logic        eCV;
        logic [15:0] eCD;
        logic        eVV;
        logic [15:0] eVD;
        logic        eWe;
        logic [14:0] eAddr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] mem [0:32767];
    vec_t vecs [$];

    ram_port_arbiter_if #(.AW(15), .DW(16)) bus ();

    ram_port_arbiter #(
        .AW(15),
        .DW(16),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read-first, one cycle latency.
    always @(posedge clk) begin
        if (bus.ram_we)
            mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    function automatic vec_t mk(
        input logic r, input logic cr, input logic cw,
        input logic [14:0] ca, input logic [15:0] cd,
        input logic vr, input logic [14:0] va,
        input logic ecg, input logic evg,
        input logic ecv, input logic [15:0] ecd,
        input logic evv, input logic [15:0] evd,
        input logic ewe, input logic [14:0] ea);
        vec_t v;
        v.rst = r;   v.cReq = cr; v.cWe = cw;
        v.cAddr = ca; v.cWd = cd;
        v.vReq = vr; v.vAddr = va;
        v.eCG = ecg; v.eVG = evg;
        v.eCV = ecv; v.eCD = ecd;
        v.eVV = evv; v.eVD = evd;
        v.eWe = ewe; v.eAddr = ea;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic cr, input logic cw,
                         input logic [14:0] ca, input logic [15:0] cd,
                         input logic vr, input logic [14:0] va);
        rst            = r;
        bus.core_req   = cr;
        bus.core_we    = cw;
        bus.core_addr  = ca;
        bus.core_wdata = cd;
        bus.vid_req    = vr;
        bus.vid_addr   = va;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int got;
        for (int a = 0; a < 32768; a++)
            mem[a] = 16'(a) ^ 16'hA5A5;
        bus.ram_rdata = '0;
        drive(1, 0, 0, 0, 0, 0, 0);

        // v0..v4: reset, core write 0x1234 @0x10, read back
        vecs.push_back(mk(1,0,0,15'h0,16'h0,   0,15'h0, 0,0,0,16'h0,0,16'h0,0,15'h0));
        vecs.push_back(mk(0,1,1,15'h10,16'h1234,0,15'h0,1,0,0,16'h0,0,16'h0,0,15'h0));
        vecs.push_back(mk(0,1,0,15'h10,16'h0,  0,15'h0, 1,0,0,16'h0,0,16'h0,1,15'h10));
        vecs.push_back(mk(0,0,0,15'h0,16'h0,   0,15'h0, 0,0,0,16'h0,0,16'h0,0,15'h0));
        vecs.push_back(mk(0,0,0,15'h0,16'h0,   0,15'h0, 0,0,1,16'h1234,0,16'h0,0,15'h0));
        // v5..v15: display streams 0..7
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(0,0,0,15'h0,16'h0, 1,15'(k), 0,1,0,16'h0,
                              k >= 2, 16'(k - 2) ^ 16'hA5A5, 0,15'h0));
        vecs.push_back(mk(0,0,0,15'h0,16'h0,   0,15'h0, 0,0,0,16'h0,1,16'h6^16'hA5A5,0,15'h0));
        vecs.push_back(mk(0,0,0,15'h0,16'h0,   0,15'h0, 0,0,0,16'h0,1,16'h7^16'hA5A5,0,15'h0));
        vecs.push_back(mk(0,0,0,15'h0,16'h0,   0,15'h0, 0,0,0,16'h0,0,16'h0,0,15'h0));
        // v16..v27: contention 4:1
        vecs.push_back(mk(0,1,0,15'h10,16'h0,  1,15'h20, 0,1,0,16'h0,0,16'h0,0,15'h0));
        vecs.push_back(mk(0,1,0,15'h10,16'h0,  1,15'h20, 0,1,0,16'h0,0,16'h0,0,15'h0));
        vecs.push_back(mk(0,1,0,15'h10,16'h0,  1,15'h20, 0,1,0,16'h0,1,PA,0,15'h0));
        vecs.push_back(mk(0,1,0,15'h10,16'h0,  1,15'h20, 0,1,0,16'h0,1,PA,0,15'h0));
        vecs.push_back(mk(0,1,0,15'h10,16'h0,  1,15'h20, 1,0,0,16'h0,1,PA,0,15'h0));
        vecs.push_back(mk(0,1,0,15'h10,16'h0,  1,15'h20, 0,1,0,16'h0,1,PA,0,15'h0));
        vecs.push_back(mk(0,1,0,15'h10,16'h0,  1,15'h20, 0,1,1,16'h1234,0,16'h0,0,15'h0));
        vecs.push_back(mk(0,1,0,15'h10,16'h0,  1,15'h20, 0,1,0,16'h0,1,PA,0,15'h0));
        vecs.push_back(mk(0,1,0,15'h10,16'h0,  1,15'h20, 0,1,0,16'h0,1,PA,0,15'h0));
        vecs.push_back(mk(0,1,0,15'h10,16'h0,  1,15'h20, 1,0,0,16'h0,1,PA,0,15'h0));
        vecs.push_back(mk(0,0,0,15'h0,16'h0,   0,15'h0, 0,0,0,16'h0,1,PA,0,15'h0));
        vecs.push_back(mk(0,0,0,15'h0,16'h0,   0,15'h0, 0,0,1,16'h1234,0,16'h0,0,15'h0));
        // v28..v37: core withdraws after 2 denied cycles, then waits 4 again
        vecs.push_back(mk(0,1,0,15'h10,16'h0,  1,15'h20, 0,1,0,16'h0,0,16'h0,0,15'h0));
        vecs.push_back(mk(0,1,0,15'h10,16'h0,  1,15'h20, 0,1,0,16'h0,0,16'h0,0,15'h0));
        vecs.push_back(mk(0,0,0,15'h0,16'h0,   1,15'h20, 0,1,0,16'h0,1,PA,0,15'h0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0,1,0,15'h10,16'h0, 1,15'h20, 0,1,0,16'h0,1,PA,0,15'h0));
        vecs.push_back(mk(0,1,0,15'h10,16'h0,  1,15'h20, 1,0,0,16'h0,1,PA,0,15'h0));
        vecs.push_back(mk(0,0,0,15'h0,16'h0,   0,15'h0, 0,0,0,16'h0,1,PA,0,15'h0));
        vecs.push_back(mk(0,0,0,15'h0,16'h0,   0,15'h0, 0,0,1,16'h1234,0,16'h0,0,15'h0));
        // v38..v44: reset the cycle after a core read grant
        vecs.push_back(mk(0,1,0,15'h10,16'h0,  0,15'h0, 1,0,0,16'h0,0,16'h0,0,15'h0));
        vecs.push_back(mk(1,0,0,15'h0,16'h0,   0,15'h0, 0,0,0,16'h0,0,16'h0,0,15'h0));
        vecs.push_back(mk(0,0,0,15'h0,16'h0,   0,15'h0, 0,0,0,16'h0,0,16'h0,0,15'h0));
        vecs.push_back(mk(0,0,0,15'h0,16'h0,   0,15'h0, 0,0,0,16'h0,0,16'h0,0,15'h0));
        vecs.push_back(mk(0,1,0,15'h10,16'h0,  0,15'h0, 1,0,0,16'h0,0,16'h0,0,15'h0));
        vecs.push_back(mk(0,0,0,15'h0,16'h0,   0,15'h0, 0,0,0,16'h0,0,16'h0,0,15'h0));
        vecs.push_back(mk(0,0,0,15'h0,16'h0,   0,15'h0, 0,0,1,16'h1234,0,16'h0,0,15'h0));
        // v45..v47: write request during reset is not granted, then goes through
        vecs.push_back(mk(1,1,1,15'h30,16'hBEEF,0,15'h0,0,0,0,16'h0,0,16'h0,0,15'h0));
        vecs.push_back(mk(0,1,1,15'h30,16'hBEEF,0,15'h0,1,0,0,16'h0,0,16'h0,0,15'h0));
        vecs.push_back(mk(0,0,0,15'h0,16'h0,   0,15'h0, 0,0,0,16'h0,0,16'h0,1,15'h30));

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            step();
            drive(v.rst, v.cReq, v.cWe, v.cAddr, v.cWd, v.vReq, v.vAddr);
            #1;
            chk($sformatf("v%0d core_gnt", i), 32'(bus.core_gnt), 32'(v.eCG));
            chk($sformatf("v%0d vid_gnt", i), 32'(bus.vid_gnt), 32'(v.eVG));
            chk($sformatf("v%0d core_rvalid", i), 32'(bus.core_rvalid), 32'(v.eCV));
            chk($sformatf("v%0d vid_rvalid", i), 32'(bus.vid_rvalid), 32'(v.eVV));
            chk($sformatf("v%0d ram_we", i), 32'(bus.ram_we), 32'(v.eWe));
            if (v.eCV)
                chk($sformatf("v%0d core_rdata", i), 32'(bus.core_rdata), 32'(v.eCD));
            if (v.eVV)
                chk($sformatf("v%0d vid_rdata", i), 32'(bus.vid_rdata), 32'(v.eVD));
            if (v.eWe) begin
                chk($sformatf("v%0d ram_addr", i), 32'(bus.ram_addr), 32'(v.eAddr));
                chk($sformatf("v%0d ram_wdata", i), 32'(bus.ram_wdata),
                    (i == 2) ? 32'h1234 : 32'hBEEF);
            end
        end

        // Reset mid-read: all outputs, including held data, return to 0.
        step();
        drive(0, 1, 0, 15'h30, 16'h0, 0, 15'h0);
        #1;
        chk("rstmid core_gnt", 32'(bus.core_gnt), 32'd1);
        step();
        drive(1, 0, 0, 15'h0, 16'h0, 0, 15'h0);
        step();
        drive(0, 0, 0, 15'h0, 16'h0, 0, 15'h0);
        #1;
        chk("rstmid gnts", {30'd0, bus.core_gnt, bus.vid_gnt}, 32'd0);
        chk("rstmid rvalids", {30'd0, bus.core_rvalid, bus.vid_rvalid}, 32'd0);
        chk("rstmid ram_we", 32'(bus.ram_we), 32'd0);
        chk("rstmid ram_addr", 32'(bus.ram_addr), 32'd0);
        chk("rstmid ram_wdata", 32'(bus.ram_wdata), 32'd0);
        chk("rstmid core_rdata", 32'(bus.core_rdata), 32'd0);
        chk("rstmid vid_rdata", 32'(bus.vid_rdata), 32'd0);
        step();
        chk("rstmid late rvalid", 32'(bus.core_rvalid), 32'd0);
        drive(0, 1, 0, 15'h30, 16'h0, 0, 15'h0);
        #1;
        chk("resume core_gnt", 32'(bus.core_gnt), 32'd1);
        step();
        drive(0, 0, 0, 15'h0, 16'h0, 0, 15'h0);
        step();
        #1;
        chk("resume core_rvalid", 32'(bus.core_rvalid), 32'd1);
        chk("resume core_rdata", 32'(bus.core_rdata), 32'hBEEF);

        // Bounded wait: core granted on the 5th cycle of continuous display.
        got = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            drive(0, 1, 0, 15'h10, 16'h0, 1, 15'h40);
            #1;
            if (bus.core_gnt) begin
                got = n;
                break;
            end
        end
        chk("starve wait cycles", 32'(got), 32'd5);
        step();
        drive(0, 0, 0, 15'h0, 16'h0, 0, 15'h0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
